postbox_tx_arbiter: RTL and testbench
=====================================

Name: postbox_tx_arbiter

Overview:
- Shares the POST transmit interface (txin / tx_pending) of the postcode core between two byte sources.
  - Port A: host-side serial receiver.
  - Port B: local keypad / status source.
- Accepts bytes over valid/ready handshakes and arbitrates round-robin.
- Presents one byte at a time to the postcode core and holds it until the core reports it has been sent on an INPUT command.
- Abandons a byte the host never collects, after a programmable timeout.

Parameters:
CLK_PER_US, 2, refclk cycles per microsecond (2 MHz refclk)
TIMEOUT_US, 10000, microseconds a byte may stay pending before it is dropped
CNT_W, 15, timeout counter width; must hold CLK_PER_US*TIMEOUT_US-1

Ports:
refclk  input  1  system clock; all logic is on its rising edge
rst_n  input  1  reset, synchronous, active-low
a_data  input  8  port A byte
a_valid  input  1  port A byte available
a_ready  output  1  port A byte accepted this cycle when a_valid is also high
b_data  input  8  port B byte
b_valid  input  1  port B byte available
b_ready  output  1  port B byte accepted this cycle when b_valid is also high
txin  output  8  byte presented to the postcode core
tx_pending  output  1  txin is valid; postcode ACKs the next INPUT command
tx_taken  input  1  one-cycle pulse from postcode when the ACK for txin is issued (byte committed)
tx_src  output  1  source of the current/last byte (0=A, 1=B)
timeout  output  1  one-cycle pulse when a pending byte is dropped

Behaviour:
- Reset state (rst_n low at a rising edge): state IDLE, txin=0x00, tx_pending=0, tx_src=0, timeout=0, counter=0, rr pointer=1.
  - The rr pointer value of 1 makes A win the first contention.
  - a_ready and b_ready are 0 while rst_n is low.
- States:
  - IDLE: no byte held.
  - PEND: byte held, tx_pending=1.
- Grant (combinational, IDLE only):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the port not equal to the rr pointer.
  - a_ready = IDLE & grant A; b_ready = IDLE & grant B. At most one ready is high at once.
  - ready may depend combinationally on the valids.
- IDLE -> PEND on the edge where the granted valid is high:
  - txin <= granted data; tx_src <= granted port; rr pointer <= granted port.
  - tx_pending <= 1; counter <= 0.
  - Latency: tx_pending is visible the cycle after the accepting cycle.
- PEND:
  - a_ready=b_ready=0. txin and tx_src are held stable.
  - counter increments each cycle.
- PEND -> IDLE on tx_taken: tx_pending <= 0 on that edge.
- PEND -> IDLE on timeout, i.e. counter == CLK_PER_US*TIMEOUT_US-1 with tx_taken low:
  - tx_pending <= 0.
  - timeout pulses high for exactly the following cycle.
  - The byte is discarded.
- tx_pending therefore stays high for at most CLK_PER_US*TIMEOUT_US cycles.
- tx_taken and the terminal count in the same cycle: taken wins, no timeout pulse.
- tx_taken in IDLE: ignored.
- After any return to IDLE, the earliest new accept is in the next cycle (IDLE lasts ≥1 cycle).
  - Consequence: tx_pending is low for at least one cycle between bytes.
- txin and tx_src are not cleared on return to IDLE; they retain the last byte.
- Reset mid-PEND: byte lost, no timeout pulse, outputs return to reset values on that edge.
- A source deasserting valid while not granted is legal; no state is kept for it.

Test Plan:
- rst_n low 3 cycles while a_valid=b_valid=1 -> a_ready=b_ready=0, txin=0x00, tx_pending=0, timeout=0 throughout.
- Single A byte 0x5A:
  - a_ready=1 in the same cycle; tx_pending=1 next cycle; txin=0x5A and tx_src=0 hold for 20 cycles.
  - tx_taken pulse -> tx_pending=0 next cycle; a_ready high again one cycle later.
- A=0x11 and B=0x22 held valid continuously; tx_taken pulsed 5 cycles after each tx_pending rise -> txin sequence 0x11,0x22,0x11,0x22, with tx_src alternating 0,1,0,1.
- CLK_PER_US=2, TIMEOUT_US=3, B byte 0xA5, no tx_taken:
  - tx_pending high exactly 6 cycles, then timeout=1 for one cycle.
  - A pending byte 0x33 is then accepted and presented.
- Same parameters, tx_taken asserted on the 6th pending cycle -> tx_pending falls, timeout stays 0.
- rst_n low for one edge during PEND with txin=0x77 -> tx_pending=0, txin=0x00, state IDLE. A subsequent A byte 0x5A is presented normally with tx_pending after one cycle.

Source files
------------

// File: rtl/postbox_tx_arbiter.sv
// Round-robin arbiter sharing the postcode transmit byte between a host serial
// source (A) and a local keypad/status source (B), with a pending-byte timeout.
module postbox_tx_arbiter #(
   parameter int unsigned CLK_PER_US = 2,
   parameter int unsigned TIMEOUT_US = 10000,
   parameter int unsigned CNT_W      = 15
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic [7:0] a_data,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] b_data,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [7:0] txin,
   output logic       tx_pending,
   input  logic       tx_taken,
   output logic       tx_src,
   output logic       timeout
);

   localparam logic IDLE = 1'b0;
   localparam logic PEND = 1'b1;

   localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_PER_US * TIMEOUT_US - 1);

   logic             state;
   logic [CNT_W-1:0] count;
   logic             rr_ptr;
   logic             grant_a;
   logic             grant_b;

   // rr_ptr holds the last granted port; on contention the other port wins
   always_comb begin
      grant_a = a_valid & (~b_valid | rr_ptr);
      grant_b = b_valid & (~a_valid | ~rr_ptr);
   end

   assign a_ready    = rst_n & (state == IDLE) & grant_a;
   assign b_ready    = rst_n & (state == IDLE) & grant_b;
   assign tx_pending = (state == PEND);

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state   <= IDLE;
         txin    <= '0;
         tx_src  <= 1'b0;
         timeout <= 1'b0;
         count   <= '0;
         rr_ptr  <= 1'b1;
      end else begin
         timeout <= 1'b0;
         if (state == IDLE) begin
            if (grant_a | grant_b) begin
               state  <= PEND;
               txin   <= grant_b ? b_data : a_data;
               tx_src <= grant_b;
               rr_ptr <= grant_b;
               count  <= '0;
            end
         end else begin
            count <= count + 1'b1;
            // a commit on the terminal cycle takes priority over the drop
            if (tx_taken) begin
               state <= IDLE;
            end else if (count == TERM) begin
               state   <= IDLE;
               timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_postbox_tx_arbiter.sv
// Directed bench for postbox_tx_arbiter: a default-timeout instance for the
// arbitration/hold behaviour and a short-timeout instance for the drop path.
module tb_postbox_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] a_data, b_data, txin;
   logic       a_valid, b_valid, a_ready, b_ready, tx_pending, tx_taken, tx_src, timeout;

   logic [7:0] s_a_data, s_b_data, s_txin;
   logic       s_a_valid, s_b_valid, s_a_ready, s_b_ready, s_pend, s_taken, s_src, s_timeout;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   postbox_tx_arbiter dut (
      .refclk(clk), .rst_n(rst_n),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .txin(txin), .tx_pending(tx_pending), .tx_taken(tx_taken),
      .tx_src(tx_src), .timeout(timeout)
   );

   postbox_tx_arbiter #(.CLK_PER_US(2), .TIMEOUT_US(3), .CNT_W(4)) dut_s (
      .refclk(clk), .rst_n(rst_n),
      .a_data(s_a_data), .a_valid(s_a_valid), .a_ready(s_a_ready),
      .b_data(s_b_data), .b_valid(s_b_valid), .b_ready(s_b_ready),
      .txin(s_txin), .tx_pending(s_pend), .tx_taken(s_taken),
      .tx_src(s_src), .timeout(s_timeout)
   );

   typedef struct {
      logic       rst_n;
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       tk;
      logic       ar;
      logic       br;
      logic       pend;
      logic [7:0] txin;
      logic       src;
      logic       to;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen;
      logic to_early;
      int   cnt;
      logic [7:0] alt_data[4];
      logic       alt_src[4];

      // rst, av, ad, bv, bd, tk | ar, br, pend, txin, src, to
      vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};

      alt_data = '{8'h11, 8'h22, 8'h11, 8'h22};
      alt_src  = '{1'b0, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0;
      a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; tx_taken = 1'b0;
      s_a_valid = 1'b0; s_a_data = 8'h00; s_b_valid = 1'b0; s_b_data = 8'h00; s_taken = 1'b0;
      tick();

      for (int i = 0; i < 13; i++) begin
         rst_n = vecs[i].rst_n;
         a_valid = vecs[i].av; a_data = vecs[i].ad;
         b_valid = vecs[i].bv; b_data = vecs[i].bd;
         tx_taken = vecs[i].tk;
         @(negedge clk);
         chk($sformatf("v%0d a_ready", i), {7'd0, a_ready}, {7'd0, vecs[i].ar});
         chk($sformatf("v%0d b_ready", i), {7'd0, b_ready}, {7'd0, vecs[i].br});
         chk($sformatf("v%0d tx_pending", i), {7'd0, tx_pending}, {7'd0, vecs[i].pend});
         chk($sformatf("v%0d txin", i), txin, vecs[i].txin);
         chk($sformatf("v%0d tx_src", i), {7'd0, tx_src}, {7'd0, vecs[i].src});
         chk($sformatf("v%0d timeout", i), {7'd0, timeout}, {7'd0, vecs[i].to});
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0; tx_taken = 1'b1;
      tick();
      tx_taken = 1'b0;
      tick();

      // single A byte held for 20 cycles, then committed
      a_valid = 1'b1; a_data = 8'h5A;
      @(negedge clk);
      chk("single a_ready", {7'd0, a_ready}, 8'd1);
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d pend", i), {7'd0, tx_pending}, 8'd1);
         chk($sformatf("hold%0d txin", i), txin, 8'h5A);
         chk($sformatf("hold%0d src", i), {7'd0, tx_src}, 8'd0);
         tick();
      end
      tx_taken = 1'b1;
      tick();
      tx_taken = 1'b0;
      a_valid = 1'b1; a_data = 8'h66;
      @(negedge clk);
      chk("after taken pend", {7'd0, tx_pending}, 8'd0);
      chk("after taken a_ready", {7'd0, a_ready}, 8'd1);
      chk("after taken txin kept", txin, 8'h5A);
      tick();
      a_valid = 1'b0;
      tx_taken = 1'b1;
      tick();
      tx_taken = 1'b0;

      // round-robin alternation from a fresh reset
      rst_n = 1'b0;
      a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (tx_pending) begin
               seen = 1'b1;
               break;
            end
         end
         chk($sformatf("alt%0d seen", k), {7'd0, seen}, 8'd1);
         chk($sformatf("alt%0d txin", k), txin, alt_data[k]);
         chk($sformatf("alt%0d src", k), {7'd0, tx_src}, {7'd0, alt_src[k]});
         repeat (5) @(posedge clk);
         #1 tx_taken = 1'b1;
         tick();
         tx_taken = 1'b0;
         if (k == 3) begin
            a_valid = 1'b0; b_valid = 1'b0;
         end
      end

      // short instance: B byte dropped after 6 pending cycles
      s_b_valid = 1'b1; s_b_data = 8'hA5;
      @(negedge clk);
      chk("to b_ready", {7'd0, s_b_ready}, 8'd1);
      tick();
      s_b_valid = 1'b0;
      s_a_valid = 1'b1; s_a_data = 8'h33;
      cnt = 0;
      to_early = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (!s_pend) break;
         cnt++;
         if (s_timeout || s_txin !== 8'hA5 || s_src !== 1'b1) to_early = 1'b1;
         @(posedge clk);
      end
      chk("to pending cycles", 8'(cnt), 8'd6);
      chk("to held/clean", {7'd0, to_early}, 8'd0);
      chk("to pulse", {7'd0, s_timeout}, 8'd1);
      chk("to a_ready", {7'd0, s_a_ready}, 8'd1);
      tick();
      s_a_valid = 1'b0;
      @(negedge clk);
      chk("to pulse width", {7'd0, s_timeout}, 8'd0);
      chk("to next pend", {7'd0, s_pend}, 8'd1);
      chk("to next txin", s_txin, 8'h33);
      chk("to next src", {7'd0, s_src}, 8'd0);

      // taken on the terminal (6th) pending cycle beats the timeout
      repeat (5) @(posedge clk);
      #1 s_taken = 1'b1;
      @(negedge clk);
      chk("term pend", {7'd0, s_pend}, 8'd1);
      tick();
      s_taken = 1'b0;
      @(negedge clk);
      chk("term pend fall", {7'd0, s_pend}, 8'd0);
      chk("term no timeout", {7'd0, s_timeout}, 8'd0);
      tick();
      @(negedge clk);
      chk("term no timeout later", {7'd0, s_timeout}, 8'd0);
      tick();

      // reset during PEND
      a_valid = 1'b1; a_data = 8'h77;
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("rst pre txin", txin, 8'h77);
      chk("rst pre pend", {7'd0, tx_pending}, 8'd1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a_valid = 1'b1; a_data = 8'h5A;
      @(negedge clk);
      chk("rst pend", {7'd0, tx_pending}, 8'd0);
      chk("rst txin", txin, 8'h00);
      chk("rst src", {7'd0, tx_src}, 8'd0);
      chk("rst timeout", {7'd0, timeout}, 8'd0);
      chk("rst a_ready", {7'd0, a_ready}, 8'd1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("rst new pend", {7'd0, tx_pending}, 8'd1);
      chk("rst new txin", txin, 8'h5A);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
